// File: rtl/s_term_cfg_relay.sv
// South-terminal tile: relays configuration frames up the column, captures its own routing
// frames on strobe rising edges, and drives N-going wires from S-arriving wires via 4:1 muxes.
module s_term_cfg_relay #(
   parameter int unsigned FRAME_BITS  = 32,
   parameter int unsigned MAX_FRAMES  = 20,
   parameter int unsigned PIPE_STAGES = 1,
   parameter int unsigned CFG_FRAMES  = 4,
   parameter int unsigned W1          = 4,
   parameter int unsigned W2          = 8,
   parameter int unsigned W4          = 16
) (
   input  logic                  CLK,
   input  logic                  resetn,
   input  logic [FRAME_BITS-1:0] FrameData,
   input  logic [MAX_FRAMES-1:0] FrameStrobe,
   output logic [FRAME_BITS-1:0] FrameData_O,
   output logic [MAX_FRAMES-1:0] FrameStrobe_O,
   input  logic [W1-1:0]         S1END,
   input  logic [W2-1:0]         S2MID,
   input  logic [W2-1:0]         S2END,
   input  logic [W4-1:0]         S4END,
   input  logic [W4-1:0]         SS4END,
   output logic [W1-1:0]         N1BEG,
   output logic [W2-1:0]         N2BEG,
   output logic [W2-1:0]         N2BEGb,
   output logic [W4-1:0]         N4BEG,
   output logic [W4-1:0]         NN4BEG,
   output logic                  ConfigDone
);

   localparam int unsigned NO_CFG   = 2 * (W1 + 2 * W2 + 2 * W4);
   localparam int unsigned CFG_BITS = CFG_FRAMES * FRAME_BITS;
   localparam int unsigned RELAY_W  = FRAME_BITS + MAX_FRAMES;
   localparam int unsigned OFS_N2   = W1;
   localparam int unsigned OFS_N2B  = W1 + W2;
   localparam int unsigned OFS_N4   = W1 + 2 * W2;
   localparam int unsigned OFS_NN4  = W1 + 2 * W2 + W4;

   if (CFG_BITS < NO_CFG || PIPE_STAGES > 3 || CFG_FRAMES > MAX_FRAMES) begin : g_param_check
      $error("s_term_cfg_relay: unsupported parameter combination");
   end

   // Frame relay: either straight wires or a shift register of {strobe, data} words
   if (PIPE_STAGES == 0) begin : g_relay_wire
      assign FrameData_O   = FrameData;
      assign FrameStrobe_O = FrameStrobe;
   end else begin : g_relay_pipe
      logic [PIPE_STAGES*RELAY_W-1:0] pipe;
      logic [PIPE_STAGES*RELAY_W-1:0] pipe_next;

      if (PIPE_STAGES == 1) begin : g_one
         assign pipe_next = {FrameStrobe, FrameData};
      end else begin : g_many
         assign pipe_next = {pipe[(PIPE_STAGES-1)*RELAY_W-1:0], FrameStrobe, FrameData};
      end

      always_ff @(posedge CLK or negedge resetn) begin
         if (!resetn) begin
            pipe <= '0;
         end else begin
            pipe <= pipe_next;
         end
      end

      assign {FrameStrobe_O, FrameData_O} = pipe[PIPE_STAGES*RELAY_W-1 -: RELAY_W];
   end

   logic [CFG_FRAMES-1:0] strobe_q;
   logic [CFG_FRAMES-1:0] frame_rise;
   logic [CFG_FRAMES-1:0] loaded_mask;
   logic [CFG_BITS-1:0]   cfg;
   logic [CFG_BITS-1:0]   cfg_next;

   assign frame_rise = FrameStrobe[CFG_FRAMES-1:0] & ~strobe_q;

   // Every frame whose strobe rises this cycle loads the same FrameData word
   for (genvar k = 0; k < CFG_FRAMES; k++) begin : g_frame
      assign cfg_next[k*FRAME_BITS +: FRAME_BITS] =
         frame_rise[k] ? FrameData : cfg[k*FRAME_BITS +: FRAME_BITS];
   end

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         strobe_q    <= '0;
         cfg         <= '0;
         loaded_mask <= '0;
         ConfigDone  <= 1'b0;
      end else begin
         strobe_q    <= FrameStrobe[CFG_FRAMES-1:0];
         cfg         <= cfg_next;
         loaded_mask <= loaded_mask | frame_rise;
         ConfigDone  <= &(loaded_mask | frame_rise);
      end
   end

   if (CFG_BITS > NO_CFG) begin : g_spare
      logic unused_cfg_bits;
      assign unused_cfg_bits = ^cfg[CFG_BITS-1:NO_CFG];
   end

   function automatic logic route(input logic [1:0] sel, input logic a1, input logic a2,
                                  input logic a4);
      case (sel)
         2'b01:   route = a1;
         2'b10:   route = a2;
         2'b11:   route = a4;
         default: route = 1'b0;
      endcase
   endfunction

   // Output j takes its select from cfg[2j+1:2j]; bit i picks its source by i modulo width
   for (genvar i = 0; i < W1; i++) begin : g_n1
      assign N1BEG[i] = route(cfg[2*i +: 2], S1END[i%W1], S2END[i%W2], S4END[i%W4]);
   end
   for (genvar i = 0; i < W2; i++) begin : g_n2
      assign N2BEG[i]  = route(cfg[2*(OFS_N2+i) +: 2], S1END[i%W1], S2END[i%W2], S4END[i%W4]);
      assign N2BEGb[i] = route(cfg[2*(OFS_N2B+i) +: 2], S1END[i%W1], S2MID[i%W2], S4END[i%W4]);
   end
   for (genvar i = 0; i < W4; i++) begin : g_n4
      assign N4BEG[i]  = route(cfg[2*(OFS_N4+i) +: 2], S1END[i%W1], S2END[i%W2], S4END[i%W4]);
      assign NN4BEG[i] = route(cfg[2*(OFS_NN4+i) +: 2], S1END[i%W1], S2END[i%W2], SS4END[i%W4]);
   end

endmodule

// File: tb/tb_s_term_cfg_relay.sv
// Bench for s_term_cfg_relay (PIPE_STAGES=2): directed and random frame traffic checked
// against a rule-level model of frame capture, relay delay and routing.
module tb_s_term_cfg_relay;

   logic        CLK;
   logic        resetn;
   logic [31:0] FrameData;
   logic [19:0] FrameStrobe;
   logic [31:0] FrameData_O;
   logic [19:0] FrameStrobe_O;
   logic [3:0]  S1END;
   logic [7:0]  S2MID, S2END;
   logic [15:0] S4END, SS4END;
   logic [3:0]  N1BEG;
   logic [7:0]  N2BEG, N2BEGb;
   logic [15:0] N4BEG, NN4BEG;
   logic        ConfigDone;

   s_term_cfg_relay #(.PIPE_STAGES(2)) dut (
      .CLK(CLK), .resetn(resetn), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
      .FrameData_O(FrameData_O), .FrameStrobe_O(FrameStrobe_O),
      .S1END(S1END), .S2MID(S2MID), .S2END(S2END), .S4END(S4END), .SS4END(SS4END),
      .N1BEG(N1BEG), .N2BEG(N2BEG), .N2BEGb(N2BEGb), .N4BEG(N4BEG), .NN4BEG(NN4BEG),
      .ConfigDone(ConfigDone)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int          n_tests = 0;
   int          n_fail  = 0;

   // Reference state: captured frame words, which frames have ever loaded, last strobe,
   // and the inputs seen at recent edges (front = what the 2-deep relay shows now)
   logic [31:0] m_frame [4];
   logic [3:0]  m_mask;
   logic [19:0] m_sq;
   logic [51:0] m_hist [$];

   function automatic void model_reset();
      for (int k = 0; k < 4; k++) m_frame[k] = 32'h0;
      m_mask = 4'h0;
      m_sq   = 20'h0;
      m_hist.delete();
      m_hist.push_back(52'h0);
      m_hist.push_back(52'h0);
   endfunction

   function automatic void model_edge();
      logic [51:0] dropped;
      for (int k = 0; k < 4; k++) begin
         if (FrameStrobe[k] && !m_sq[k]) begin
            m_frame[k] = FrameData;
            m_mask[k]  = 1'b1;
         end
      end
      m_sq = FrameStrobe;
      m_hist.push_back({FrameStrobe, FrameData});
      dropped = m_hist.pop_front();
   endfunction

   // Expected level of output j (bit i of its group); mid/ss pick the alternate sources
   function automatic logic exp_bit(int j, int i, bit mid, bit ss);
      logic [127:0] cfgv;
      logic [1:0]   sel;
      cfgv = {m_frame[3], m_frame[2], m_frame[1], m_frame[0]};
      sel  = cfgv[2*j +: 2];
      case (sel)
         2'd1:    return S1END[i % 4];
         2'd2:    return mid ? S2MID[i % 8] : S2END[i % 8];
         2'd3:    return ss ? SS4END[i % 16] : S4END[i % 16];
         default: return 1'b0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [3:0]  e1;
      logic [7:0]  e2, e2b;
      logic [15:0] e4, e44;
      logic [51:0] relay;
      for (int i = 0; i < 4; i++)  e1[i]  = exp_bit(i, i, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++)  e2[i]  = exp_bit(4 + i, i, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++)  e2b[i] = exp_bit(12 + i, i, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) e4[i]  = exp_bit(20 + i, i, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) e44[i] = exp_bit(36 + i, i, 1'b0, 1'b1);
      relay = m_hist[0];
      check("FrameData_O",   64'(FrameData_O),   64'(relay[31:0]));
      check("FrameStrobe_O", 64'(FrameStrobe_O), 64'(relay[51:32]));
      check("N1BEG",  64'(N1BEG),  64'(e1));
      check("N2BEG",  64'(N2BEG),  64'(e2));
      check("N2BEGb", 64'(N2BEGb), 64'(e2b));
      check("N4BEG",  64'(N4BEG),  64'(e4));
      check("NN4BEG", 64'(NN4BEG), 64'(e44));
      check("ConfigDone", 64'(ConfigDone), 64'(&m_mask));
   endtask

   task automatic randomize_s();
      S1END  = 4'($urandom);
      S2MID  = 8'($urandom);
      S2END  = 8'($urandom);
      S4END  = 16'($urandom);
      SS4END = 16'($urandom);
   endtask

   // One clock: present inputs, let the model take the edge, then compare after the edge
   task automatic step(input logic [31:0] d, input logic [19:0] s);
      FrameData   = d;
      FrameStrobe = s;
      randomize_s();
      #1;
      model_edge();
      @(posedge CLK);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge CLK);
      #1;
      check_all();
      resetn = 1'b1;
   endtask

   logic [31:0] first_word;

   initial begin
      resetn      = 1'b0;
      FrameData   = 32'h0;
      FrameStrobe = 20'h0;
      S1END = '1; S2MID = '1; S2END = '1; S4END = '1; SS4END = '1;
      model_reset();
      #2;
      check_all();
      @(posedge CLK);
      #1;
      check("reset_N4BEG", 64'(N4BEG), 64'h0);
      check("reset_done", 64'(ConfigDone), 64'h0);
      check("reset_relay", 64'(FrameData_O), 64'h0);
      resetn = 1'b1;

      // Strobe beyond the config range: relayed two cycles later, never captured
      step(32'hA5A5_0001, 20'h80000);
      check("relay_lat1", 64'(FrameData_O), 64'h0);
      step(32'h0, 20'h0);
      check("relay_data", 64'(FrameData_O), 64'hA5A5_0001);
      check("relay_strobe", 64'(FrameStrobe_O), 64'h80000);
      step(32'h0, 20'h0);
      check("no_capture_done", 64'(ConfigDone), 64'h0);

      // All four frames selecting the single-hop source
      for (int k = 0; k < 4; k++) begin
         step(32'h5555_5555, 20'(1 << k));
         check("done_progress", 64'(ConfigDone), 64'(k == 3));
         step(32'h0, 20'h0);
      end
      check("n1_s1", 64'(N1BEG), 64'(S1END));
      check("n2_s1", 64'(N2BEG), 64'({2{S1END}}));
      check("n4_s1", 64'(N4BEG), 64'({4{S1END}}));
      check("nn4_s1", 64'(NN4BEG), 64'({4{S1END}}));

      step(32'hFFFF_FFFF, 20'h1);
      check("n1_s4", 64'(N1BEG), 64'(S4END[3:0]));
      check("n2_s4", 64'(N2BEG), 64'(S4END[7:0]));
      step(32'hAAAA_AAAA, 20'h0);
      step(32'hAAAA_AAAA, 20'h1);
      check("n1_s2", 64'(N1BEG), 64'(S2END[3:0]));
      check("n2b_mid", 64'(N2BEGb[3:0]), 64'(S2MID[3:0]));
      check("done_kept", 64'(ConfigDone), 64'h1);

      // Held strobe: only the first cycle's word is captured
      first_word = $urandom;
      step(first_word, 20'h2);
      for (int c = 0; c < 4; c++) step($urandom, 20'h2);
      step($urandom, 20'h0);

      // Random frame traffic, including multiple simultaneous strobes
      for (int c = 0; c < 300; c++) begin
         if ($urandom_range(3) == 0) step($urandom, 20'($urandom));
         else step($urandom, 20'h0);
      end

      // Reset mid-load discards frames; reloading only 2 and 3 leaves config incomplete
      do_reset();
      step($urandom, 20'h1);
      step($urandom, 20'h2);
      step(32'h0, 20'h0);
      do_reset();
      check("rst_n1", 64'(N1BEG), 64'h0);
      check("rst_nn4", 64'(NN4BEG), 64'h0);
      step($urandom, 20'h4);
      step($urandom, 20'h8);
      step(32'h0, 20'h0);
      check("partial_done", 64'(ConfigDone), 64'h0);

      // Strobe already high as reset releases still captures on the first clock
      FrameStrobe = 20'h1;
      do_reset();
      step(32'h1234_5678, 20'h1);
      step(32'h0, 20'h0);
      for (int k = 1; k < 4; k++) begin
         step($urandom, 20'(1 << k));
         step(32'h0, 20'h0);
      end
      check("release_done", 64'(ConfigDone), 64'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
